coin_detector: RTL and testbench
================================

# coin_detector

Front-end stage of the soda machine: conditions three raw shape-sensor lines (circle, triangle, pentagon) into the 2-bit `CoinValue` code consumed by the vending FSM. It synchronizes and debounces the sensors, rejects multi-shape jams, and holds a stable nonzero code for the whole time a coin is present. It then forces a clean all-zero gap so the downstream FSM sees exactly one assert/deassert pair per coin.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles needed to accept a coin, release a coin, or clear a jam. Legal range is 2..15.
- `MIN_GAP_CYCLES`, default 2: cycles `CoinValue` is forced to 00 after a release. Legal range is 1..15.
- `clock` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `circle` input, 1 bit: raw circle sensor, asynchronous.
- `triangle` input, 1 bit: raw triangle sensor, asynchronous.
- `pentagon` input, 1 bit: raw pentagon sensor, asynchronous.
- `CoinValue` output, 2 bits: 01 = circle, 10 = triangle, 11 = pentagon, 00 = no coin. Registered.
- `jam` output, 1 bit: high while more than one sensor is asserted or the jam has not yet cleared. Registered.
- `coinCount` output, 8 bits: number of accepted coins, wraps. Registered.

## Operation
- Synchronization:
  - Each raw line passes through a 2-flop synchronizer.
  - `pattern = {pentagon_s, triangle_s, circle_s}`.
- IDLE:
  - `CoinValue` = 00, `jam` = 0.
  - If `pattern` is one-hot: latch it as `cand`, set cnt = 1, go to QUALIFY.
  - If `pattern` has 2 or more bits set: go to JAM.
  - If `pattern` = 000: stay.
- QUALIFY:
  - If `pattern == cand`: cnt++.
  - When cnt reaches `DEBOUNCE_CYCLES`: go to PRESENT, increment `coinCount`, and register `CoinValue = encode(cand)`.
  - On any mismatch: go to IDLE, cnt = 0. A mismatch includes a second bit appearing.
- PRESENT:
  - `CoinValue` is held at `encode(cand)`.
  - Mismatch cycles (`pattern != cand`) increment cnt; a matching cycle resets cnt to 0.
  - When cnt reaches `DEBOUNCE_CYCLES`: go to RELEASE and register `CoinValue` = 00.
- RELEASE:
  - `CoinValue` = 00 for `MIN_GAP_CYCLES` cycles, regardless of input.
  - After the gap: go to IDLE only if `pattern` = 000; otherwise wait until it is 000. A coin left in place is never double-counted.
- JAM:
  - `jam` = 1, `CoinValue` = 00.
  - Count consecutive `pattern` = 000 cycles; any nonzero pattern resets the count.
  - At `DEBOUNCE_CYCLES` zero cycles: `jam` = 0, go to IDLE.
  - No coin is counted for a jam.
- `coinCount`: +1 per PRESENT entry, 8-bit, 255 → 0.
- Reset (asynchronous, any state):
  - State = IDLE; `CoinValue` = 00, `jam` = 0, `coinCount` = 0.
  - Synchronizer flops and cnt = 0.
  - A coin still held at reset release is re-qualified as a new coin.

## Timing
- Accept latency: raw line first sampled high at edge 1 and held → `CoinValue` valid after edge `DEBOUNCE_CYCLES`+2. This is edge 6 at default parameters.
- Release latency: raw line first sampled low at edge 1 → `CoinValue` = 00 after edge `DEBOUNCE_CYCLES`+2.
- Minimum `CoinValue` = 00 gap between two coins: `MIN_GAP_CYCLES` + `DEBOUNCE_CYCLES` + 1 cycles.
- `CoinValue` never transitions directly between two nonzero codes.
- `CoinValue` and `jam` are never simultaneously active.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles:
  - In IDLE/QUALIFY: never produce a coin.
  - In PRESENT: never drop the coin.

## Structure
- Shared package `coin_pkg`:
  - `coin_t` enum: NONE = 2'b00, CIRCLE = 2'b01, TRIANGLE = 2'b10, PENTAGON = 2'b11.
  - `det_state_t` enum: IDLE, QUALIFY, PRESENT, RELEASE, JAM.
  - `encode_shape()` function: 3-bit one-hot → `coin_t`.
  - The vending FSM imports `coin_t` from the same package.
- Sub-module `coin_sync`: a 2-flop synchronizer with asynchronous reset to 0, instantiated 3 times.
- Main module: one shared 4-bit cnt plus the state register and output registers.

## Test plan
- Clean coin: triangle high for 20 cycles, then low.
  - `CoinValue` = 10 from edge 6 until 6 edges after the fall.
  - `coinCount` = 1, and exactly one nonzero pulse.
- Bounce on insertion: circle toggles 1-0-1-0 (1 cycle each), then holds 10 cycles.
  - No early `CoinValue`.
  - Exactly one 01 pulse, `coinCount` = 1.
- Dropout during presence: pentagon held 30 cycles with a 2-cycle low glitch at cycle 15.
  - `CoinValue` stays 11 continuously.
  - One count only.
- Jam: circle and triangle high together for 8 cycles, then both low.
  - `jam` = 1 and `CoinValue` = 00 throughout.
  - `jam` clears 4 zero-cycles after the release is synchronized.
  - `coinCount` unchanged.
- Back-to-back and wrap: 256 clean circle coins separated by minimum gaps.
  - Each produces a single 01 pulse with a ≥2-cycle 00 gap.
  - `coinCount` returns to 0.
- Reset mid-coin: assert `reset` while in PRESENT with triangle held.
  - `CoinValue` = 00 and `coinCount` = 0 immediately, without waiting for a clock edge.
  - After reset deasserts, triangle is re-accepted after 6 edges.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared coin codes, detector states and the shape encoder used by the
// coin detector and the vending FSM.
package coin_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    CIRCLE   = 2'b01,
    TRIANGLE = 2'b10,
    PENTAGON = 2'b11
  } coin_t;

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    PRESENT,
    RELEASE,
    JAM
  } det_state_t;

  localparam int CNT_W = 4;

  function automatic coin_t encode_shape(input logic [2:0] shape);
    coin_t code;
    case (shape)
      3'b001:  code = CIRCLE;
      3'b010:  code = TRIANGLE;
      3'b100:  code = PENTAGON;
      default: code = NONE;
    endcase
    return code;
  endfunction

  function automatic logic is_onehot(input logic [2:0] shape);
    return (shape == 3'b001) || (shape == 3'b010) || (shape == 3'b100);
  endfunction

endpackage

// File: rtl/coin_sync.sv
// Two-flop synchronizer for one raw sensor line, cleared by the async reset.
module coin_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/coin_detector.sv
// Sensor front end: synchronizes and debounces the three shape lines, rejects
// jams and emits one clean CoinValue pulse per coin with a forced idle gap.
module coin_detector
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_GAP_CYCLES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       circle,
  input  logic       triangle,
  input  logic       pentagon,
  output logic [1:0] CoinValue,
  output logic       jam,
  output logic [7:0] coinCount
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(MIN_GAP_CYCLES);

  logic [2:0] raw;
  logic [2:0] pattern;

  assign raw = {pentagon, triangle, circle};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      coin_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d     (raw[gi]),
        .q     (pattern[gi])
      );
    end
  endgenerate

  det_state_t       state_reg;
  logic [2:0]       cand_reg;
  logic [CNT_W-1:0] cnt_reg;
  coin_t            coin_value_reg;
  logic             jam_reg;
  logic [7:0]       count_reg;

  // cnt is shared: qualify matches, present mismatches, release gap, jam zeros.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cand_reg       <= 3'b000;
      cnt_reg        <= '0;
      coin_value_reg <= NONE;
      jam_reg        <= 1'b0;
      count_reg      <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_onehot(pattern)) begin
            cand_reg  <= pattern;
            cnt_reg   <= CNT_W'(1);
            state_reg <= QUALIFY;
          end else if (pattern != 3'b000) begin
            cnt_reg   <= '0;
            jam_reg   <= 1'b1;
            state_reg <= JAM;
          end
        end
        QUALIFY: begin
          if (pattern == cand_reg) begin
            if (cnt_reg == DEB_LAST) begin
              cnt_reg        <= '0;
              coin_value_reg <= encode_shape(cand_reg);
              count_reg      <= count_reg + 8'd1;
              state_reg      <= PRESENT;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end else begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end
        end
        PRESENT: begin
          if (pattern != cand_reg) begin
            if (cnt_reg == DEB_LAST) begin
              cnt_reg        <= '0;
              coin_value_reg <= NONE;
              state_reg      <= RELEASE;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end else begin
            cnt_reg <= '0;
          end
        end
        RELEASE: begin
          // Gap runs unconditionally; a coin left in place then holds us here.
          if (cnt_reg != GAP_LEN) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end else if (pattern == 3'b000) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end
        end
        JAM: begin
          if (pattern == 3'b000) begin
            if (cnt_reg == DEB_LAST) begin
              cnt_reg   <= '0;
              jam_reg   <= 1'b0;
              state_reg <= IDLE;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end else begin
            cnt_reg <= '0;
          end
        end
        default: begin
          cnt_reg        <= '0;
          coin_value_reg <= NONE;
          jam_reg        <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  assign CoinValue = coin_value_reg;
  assign jam       = jam_reg;
  assign coinCount = count_reg;

endmodule

// File: tb/tb_coin_detector.sv
// Randomized scoreboard bench for coin_detector: stimulus predicts coin and jam
// pulses from the timing rules; a monitor checks each pulse as it completes.
module tb_coin_detector;

  localparam int D = 4;
  localparam int G = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       circle = 1'b0;
  logic       triangle = 1'b0;
  logic       pentagon = 1'b0;
  logic [1:0] CoinValue;
  logic       jam;
  logic [7:0] coinCount;

  coin_detector #(
    .DEBOUNCE_CYCLES (D),
    .MIN_GAP_CYCLES  (G)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .circle    (circle),
    .triangle  (triangle),
    .pentagon  (pentagon),
    .CoinValue (CoinValue),
    .jam       (jam),
    .coinCount (coinCount)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int code;
    int count;
    int rise;
    int fall;
  } coin_exp_t;

  typedef struct {
    int rise;
    int fall;
  } jam_exp_t;

  coin_exp_t coin_q[$];
  jam_exp_t  jam_q[$];

  int errors = 0;
  int checks = 0;
  int model_count = 0;
  int coins_issued = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic [2:0] p);
    @(posedge clock);
    #1;
    {pentagon, triangle, circle} = p;
  endtask

  // One coin of the given code; accept/release edges follow from when the raw
  // line is first sampled high (s) and first sampled low (f).
  task automatic run_coin(input int code, input int hold, input bit bounce,
                          input bit glitch, input int low);
    logic [2:0] shape;
    logic [2:0] gpat;
    logic [2:0] p;
    coin_exp_t  e;
    int s, f, gs, gl, nb;
    shape = 3'b001 << (code - 1);
    gs = 0;
    gl = 0;
    gpat = 3'b000;
    if (bounce) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(1, D - 1)) step(shape);
        repeat ($urandom_range(1, 3)) step(3'b000);
      end
    end
    if (glitch) begin
      gl = $urandom_range(1, D - 1);
      gs = $urandom_range(D + 2, hold - gl - 2);
      do gpat = 3'($urandom_range(0, 7)); while (gpat == shape);
    end
    s = 0;
    for (int i = 0; i < hold; i++) begin
      p = (glitch && i >= gs && i < gs + gl) ? gpat : shape;
      step(p);
      if (i == 0) s = cyc + 1;
    end
    step(3'b000);
    f = cyc + 1;
    model_count = (model_count + 1) % 256;
    coins_issued++;
    e.code = code;
    e.count = model_count;
    e.rise = s + D + 1;
    e.fall = f + D + 1;
    coin_q.push_back(e);
    repeat (low - 1) step(3'b000);
  endtask

  task automatic run_jam(input logic [2:0] jp, input int len, input int low);
    jam_exp_t e;
    int s, f;
    step(jp);
    s = cyc + 1;
    repeat (len - 1) step(jp);
    step(3'b000);
    f = cyc + 1;
    e.rise = s + 2;
    e.fall = f + D + 1;
    jam_q.push_back(e);
    repeat (low - 1) step(3'b000);
  endtask

  task automatic run_noise();
    int n;
    logic [2:0] shape;
    n = $urandom_range(1, 3);
    for (int b = 0; b < n; b++) begin
      shape = 3'b001 << $urandom_range(0, 2);
      repeat ($urandom_range(1, D - 1)) step(shape);
      repeat ($urandom_range(1, 3)) step(3'b000);
    end
  endtask

  // Monitor: completes a coin or jam transaction on each falling output.
  logic [1:0] prev_cv = 2'b00;
  logic       prev_jam = 1'b0;
  int rise_cyc = 0, rise_cv = 0, rise_cnt = 0, jam_rise_cyc = 0;

  always @(negedge clock) begin
    coin_exp_t ce;
    jam_exp_t  je;
    if (!mon_en) begin
      prev_cv = 2'b00;
      prev_jam = 1'b0;
    end else begin
      check("jam_and_coin_exclusive", int'(jam && (CoinValue != 2'b00)), 0);
      if (prev_cv != 2'b00 && CoinValue != 2'b00)
        check("no_direct_code_change", int'(CoinValue), int'(prev_cv));
      if (prev_cv == 2'b00 && CoinValue != 2'b00) begin
        rise_cyc = cyc;
        rise_cv = int'(CoinValue);
        rise_cnt = int'(coinCount);
      end
      if (prev_cv != 2'b00 && CoinValue == 2'b00) begin
        if (coin_q.size() == 0) begin
          check("unexpected_coin_pulse", rise_cv, 0);
        end else begin
          ce = coin_q.pop_front();
          check("coin_code", rise_cv, ce.code);
          check("coin_count", rise_cnt, ce.count);
          check("coin_rise_edge", rise_cyc, ce.rise);
          check("coin_fall_edge", cyc, ce.fall);
        end
      end
      if (!prev_jam && jam) jam_rise_cyc = cyc;
      if (prev_jam && !jam) begin
        if (jam_q.size() == 0) begin
          check("unexpected_jam_pulse", 1, 0);
        end else begin
          je = jam_q.pop_front();
          check("jam_rise_edge", jam_rise_cyc, je.rise);
          check("jam_fall_edge", cyc, je.fall);
        end
      end
      prev_cv = CoinValue;
      prev_jam = jam;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, hold, low, s, f, waited;
    bit gl, bn;
    coin_exp_t e;
    logic [2:0] jpats [4];
    jpats[0] = 3'b011;
    jpats[1] = 3'b101;
    jpats[2] = 3'b110;
    jpats[3] = 3'b111;

    repeat (3) @(posedge clock);
    #1;
    check("reset_coinvalue", int'(CoinValue), 0);
    check("reset_jam", int'(jam), 0);
    check("reset_count", int'(coinCount), 0);
    #2;
    reset = 1'b0;
    mon_en = 1'b1;

    // Directed scenarios first: clean, bounce, dropout, jam, minimum-length hold.
    run_coin(2, 20, 1'b0, 1'b0, D + G + 4);
    run_coin(1, 10, 1'b1, 1'b0, D + G + 4);
    run_coin(3, 30, 1'b0, 1'b1, D + G + 4);
    run_jam(3'b011, 8, D + 4);
    run_coin(1, D, 1'b0, 1'b0, D + G + 1);
    run_noise();
    repeat (D + G + 6) step(3'b000);
    check("count_after_directed", int'(coinCount), model_count);

    // Random mix; enough coins to wrap the 8-bit counter.
    while (coins_issued < 270) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        gl = 1'($urandom_range(0, 1));
        bn = 1'($urandom_range(0, 1));
        hold = gl ? $urandom_range(2 * D + 4, 28) : $urandom_range(D, 20);
        low = $urandom_range(0, 1) ? (D + G + 1) : $urandom_range(D + G + 1, D + G + 8);
        run_coin($urandom_range(1, 3), hold, bn, gl, low);
      end else if (r <= 7) begin
        run_noise();
      end else begin
        run_jam(jpats[$urandom_range(0, 3)], $urandom_range(1, 6), $urandom_range(D + 2, D + 6));
      end
    end
    repeat (D + G + 10) step(3'b000);
    check("count_after_wrap", int'(coinCount), model_count);
    check("coin_queue_drained", coin_q.size(), 0);
    check("jam_queue_drained", jam_q.size(), 0);

    // Reset while a triangle is present, then expect re-acceptance as coin 1.
    mon_en = 1'b0;
    step(3'b010);
    waited = 0;
    while (CoinValue == 2'b00 && waited < 3 * D + 10) begin
      step(3'b010);
      waited++;
    end
    check("reset_test_present", int'(CoinValue), 2);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_coinvalue", int'(CoinValue), 0);
    check("async_reset_count", int'(coinCount), 0);
    check("async_reset_jam", int'(jam), 0);
    @(posedge clock);
    #3;
    reset = 1'b0;
    s = cyc + 1;
    model_count = 0;
    mon_en = 1'b1;
    repeat (12) step(3'b010);
    step(3'b000);
    f = cyc + 1;
    model_count = model_count + 1;
    e.code = 2;
    e.count = model_count;
    e.rise = s + D + 1;
    e.fall = f + D + 1;
    coin_q.push_back(e);
    repeat (D + G + 6) step(3'b000);
    check("count_after_reset_coin", int'(coinCount), 1);
    check("final_coin_queue_drained", coin_q.size(), 0);
    check("final_jam_queue_drained", jam_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
